// File: rtl/reorder_buffer_pkg.sv
// Shared configuration for the reorder buffer: instruction class encodings,
// buffer geometry and common data widths.
package reorder_buffer_pkg;

  typedef enum logic [1:0] {
    Other_Type  = 2'b00,
    Jalr_Type   = 2'b01,
    Branch_Type = 2'b10,
    Store_Type  = 2'b11
  } inst_type_e;

  localparam int   ROB_DEPTH    = 16;
  localparam int   Rob_Addr_Len = 4;
  localparam int   Data_Len     = 32;
  localparam int   Addr_Len     = 32;
  localparam logic True         = 1'b1;
  localparam logic False        = 1'b0;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at issue, captures ALU/SLB
// results, answers operand-readiness queries by tag and commits in order
// (register write, store release, or misbranch redirect).
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ROB_AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue_rob,
  input  logic [1:0]        inst_type,
  input  logic [4:0]        dest,
  input  logic              has_jump,
  input  logic [31:0]       pc,
  input  logic [ROB_AW-1:0] rs1_rob_num,
  input  logic [ROB_AW-1:0] rs2_rob_num,
  output logic              rob_avail,
  output logic [ROB_AW-1:0] rob_avail_num,
  output logic              rob_rs1_ready,
  output logic              rob_rs2_ready,
  output logic [31:0]       rob_rs1_data,
  output logic [31:0]       rob_rs2_data,
  input  logic              alu_valid,
  input  logic [ROB_AW-1:0] alu_robnum,
  input  logic [31:0]       alu_result,
  input  logic              alu_jump,
  input  logic [31:0]       alu_target,
  input  logic              slb_valid,
  input  logic [ROB_AW-1:0] slb_robnum,
  input  logic [31:0]       slb_result,
  output logic              commit_valid,
  output logic [4:0]        commit_rd,
  output logic [ROB_AW-1:0] commit_robnum,
  output logic [31:0]       commit_data,
  output logic              commit_store,
  output logic [ROB_AW-1:0] commit_store_robnum,
  output logic              has_misbranch,
  output logic [31:0]       target_pc
);
  import reorder_buffer_pkg::*;

  logic [ROB_AW-1:0]   head;
  logic [ROB_AW-1:0]   tail;
  logic [ROB_AW:0]     count;

  logic                busy      [ROB_DEPTH];
  logic                ready     [ROB_DEPTH];
  inst_type_e          ent_type  [ROB_DEPTH];
  logic [4:0]          ent_dest  [ROB_DEPTH];
  logic [Addr_Len-1:0] ent_pc    [ROB_DEPTH];
  logic                pred_jump [ROB_DEPTH];
  logic [Data_Len-1:0] value     [ROB_DEPTH];
  logic                act_jump  [ROB_DEPTH];
  logic [Addr_Len-1:0] target    [ROB_DEPTH];

  logic                commit_en;
  logic                head_mis;
  logic                flush;
  logic                issue_en;
  logic                res_en;
  logic [ROB_AW+1:0]   count_plus;

  // Operand lookup: a captured entry wins, then the ALU bus, then the SLB bus.
  function automatic logic [Data_Len:0] lookup(input logic [ROB_AW-1:0] tag);
    logic [Data_Len:0] r;
    r = '0;
    if (ready[tag])
      r = {1'b1, value[tag]};
    else if (alu_valid && alu_robnum == tag)
      r = {1'b1, alu_result};
    else if (slb_valid && slb_robnum == tag)
      r = {1'b1, slb_result};
    return r;
  endfunction

  // Commit/flush decode for the head entry and gating of incoming traffic.
  always_comb begin
    commit_en = (count != '0) && busy[head] && ready[head] && !has_misbranch;
    head_mis  = 1'b0;
    case (ent_type[head])
      Branch_Type: head_mis = (act_jump[head] != pred_jump[head]);
      Jalr_Type:   head_mis = 1'b1;
      default:     head_mis = 1'b0;
    endcase
    flush    = commit_en && head_mis;
    issue_en = issue_rob && !has_misbranch && !flush;
    res_en   = !has_misbranch;
  end

  // Issue-side availability and operand queries.
  always_comb begin
    count_plus    = {1'b0, count} + {{(ROB_AW+1){1'b0}}, issue_rob};
    rob_avail     = (count_plus <= (ROB_AW+2)'(ROB_DEPTH - 2));
    rob_avail_num = tail + {{(ROB_AW-1){1'b0}}, issue_rob};
    {rob_rs1_ready, rob_rs1_data} = lookup(rs1_rob_num);
    {rob_rs2_ready, rob_rs2_data} = lookup(rs2_rob_num);
  end

  // Pointer/count maintenance, entry writes and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head                <= '0;
      tail                <= '0;
      count               <= '0;
      commit_valid        <= 1'b0;
      commit_rd           <= '0;
      commit_robnum       <= '0;
      commit_data         <= '0;
      commit_store        <= 1'b0;
      commit_store_robnum <= '0;
      has_misbranch       <= 1'b0;
      target_pc           <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        busy[i]  <= 1'b0;
        ready[i] <= 1'b0;
      end
    end else if (rdy) begin
      commit_valid  <= 1'b0;
      commit_store  <= 1'b0;
      has_misbranch <= 1'b0;

      if (commit_en) begin
        case (ent_type[head])
          Other_Type: begin
            commit_valid  <= 1'b1;
            commit_rd     <= ent_dest[head];
            commit_data   <= value[head];
            commit_robnum <= head;
          end
          Store_Type: begin
            commit_store        <= 1'b1;
            commit_store_robnum <= head;
          end
          Branch_Type: begin
            if (head_mis) begin
              has_misbranch <= 1'b1;
              target_pc     <= act_jump[head] ? target[head] : ent_pc[head] + 32'd4;
            end
          end
          Jalr_Type: begin
            commit_valid  <= 1'b1;
            commit_rd     <= ent_dest[head];
            commit_data   <= value[head];
            commit_robnum <= head;
            has_misbranch <= 1'b1;
            target_pc     <= target[head];
          end
          default: ;
        endcase
      end

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int unsigned i = 0; i < ROB_DEPTH; i++)
          busy[i] <= 1'b0;
      end else begin
        if (commit_en) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        count <= count + {{ROB_AW{1'b0}}, issue_en} - {{ROB_AW{1'b0}}, commit_en};
        if (issue_en) begin
          busy[tail]      <= 1'b1;
          ready[tail]     <= 1'b0;
          ent_type[tail]  <= inst_type_e'(inst_type);
          ent_dest[tail]  <= dest;
          ent_pc[tail]    <= pc;
          pred_jump[tail] <= has_jump;
          tail            <= tail + 1'b1;
        end
        // Result writes follow the issue write so distinct-tag captures land.
        if (alu_valid && res_en) begin
          value[alu_robnum]    <= alu_result;
          act_jump[alu_robnum] <= alu_jump;
          target[alu_robnum]   <= alu_target;
          ready[alu_robnum]    <= 1'b1;
        end
        if (slb_valid && res_en) begin
          value[slb_robnum] <= slb_result;
          ready[slb_robnum] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based program-order model plus directed
// scenarios with literal expectations, followed by randomized traffic.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk, rst, rdy, issue_rob, has_jump;
  logic [1:0]    inst_type;
  logic [4:0]    dest;
  logic [31:0]   pc;
  logic [AW-1:0] rs1_rob_num, rs2_rob_num;
  logic          rob_avail;
  logic [AW-1:0] rob_avail_num;
  logic          rob_rs1_ready, rob_rs2_ready;
  logic [31:0]   rob_rs1_data, rob_rs2_data;
  logic          alu_valid, alu_jump;
  logic [AW-1:0] alu_robnum;
  logic [31:0]   alu_result, alu_target;
  logic          slb_valid;
  logic [AW-1:0] slb_robnum;
  logic [31:0]   slb_result;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [AW-1:0] commit_robnum;
  logic [31:0]   commit_data;
  logic          commit_store;
  logic [AW-1:0] commit_store_robnum;
  logic          has_misbranch;
  logic [31:0]   target_pc;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .ROB_AW(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_rob(issue_rob), .inst_type(inst_type),
    .dest(dest), .has_jump(has_jump), .pc(pc), .rs1_rob_num(rs1_rob_num),
    .rs2_rob_num(rs2_rob_num), .rob_avail(rob_avail), .rob_avail_num(rob_avail_num),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_data(rob_rs1_data), .rob_rs2_data(rob_rs2_data),
    .alu_valid(alu_valid), .alu_robnum(alu_robnum), .alu_result(alu_result),
    .alu_jump(alu_jump), .alu_target(alu_target), .slb_valid(slb_valid),
    .slb_robnum(slb_robnum), .slb_result(slb_result), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_robnum(commit_robnum), .commit_data(commit_data),
    .commit_store(commit_store), .commit_store_robnum(commit_store_robnum),
    .has_misbranch(has_misbranch), .target_pc(target_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        pred;
    logic        done;
    logic [31:0] value;
    logic        act;
    logic [31:0] target;
  } ent_t;

  // Model: in-flight instructions in program order; head tag is implied.
  ent_t        q[$];
  logic [3:0]  m_tail;
  logic        m_mis;
  logic        e_cv, e_cs;
  logic [4:0]  e_rd;
  logic [3:0]  e_robnum, e_csrob;
  logic [31:0] e_data, e_target;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [3:0] tag);
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic check_query(input string name, input logic [3:0] tag,
                             input logic r_act, input logic [31:0] d_act);
    int idx;
    logic        r_exp;
    logic [31:0] d_exp;
    idx = find(tag);
    if (idx < 0) return;
    r_exp = 1'b1;
    d_exp = '0;
    if (q[idx].done) d_exp = q[idx].value;
    else if (alu_valid && alu_robnum == tag) d_exp = alu_result;
    else if (slb_valid && slb_robnum == tag) d_exp = slb_result;
    else r_exp = 1'b0;
    chk({name, "_ready"}, 32'(r_act), 32'(r_exp));
    if (r_exp) chk({name, "_data"}, d_act, d_exp);
  endtask

  task automatic check_comb();
    int sz;
    sz = q.size();
    chk("rob_avail", 32'(rob_avail), 32'((sz + int'(issue_rob)) <= DEPTH - 2));
    chk("rob_avail_num", 32'(rob_avail_num), 32'(4'(m_tail + 4'(issue_rob))));
    check_query("rs1", rs1_rob_num, rob_rs1_ready, rob_rs1_data);
    check_query("rs2", rs2_rob_num, rob_rs2_ready, rob_rs2_data);
  endtask

  task automatic model_edge();
    ent_t e;
    int   idx;
    if (rst) begin
      q.delete(); m_tail = '0; m_mis = 1'b0;
      e_cv = 1'b0; e_cs = 1'b0; e_rd = '0; e_robnum = '0; e_csrob = '0;
      e_data = '0; e_target = '0;
      return;
    end
    if (!rdy) return;
    e_cv = 1'b0;
    e_cs = 1'b0;
    if (m_mis) begin
      m_mis = 1'b0;
      return;
    end
    if (q.size() > 0 && q[0].done) begin
      e = q.pop_front();
      if (e.typ == Other_Type || e.typ == Jalr_Type) begin
        e_cv = 1'b1; e_rd = e.dest; e_data = e.value; e_robnum = e.tag;
      end
      if (e.typ == Store_Type) begin
        e_cs = 1'b1; e_csrob = e.tag;
      end
      if (e.typ == Jalr_Type) begin
        m_mis = 1'b1; e_target = e.target;
      end
      if (e.typ == Branch_Type && e.act != e.pred) begin
        m_mis = 1'b1; e_target = e.act ? e.target : e.pc + 32'd4;
      end
      if (m_mis) begin
        q.delete();
        m_tail = '0;
        return;
      end
    end
    if (alu_valid) begin
      idx = find(alu_robnum);
      if (idx >= 0) begin
        q[idx].done = 1'b1; q[idx].value = alu_result;
        q[idx].act = alu_jump; q[idx].target = alu_target;
      end
    end
    if (slb_valid) begin
      idx = find(slb_robnum);
      if (idx >= 0) begin
        q[idx].done = 1'b1; q[idx].value = slb_result;
      end
    end
    if (issue_rob) begin
      e = '{tag: m_tail, typ: inst_type, dest: dest, pc: pc, pred: has_jump,
            done: 1'b0, value: '0, act: 1'b0, target: '0};
      q.push_back(e);
      m_tail = m_tail + 4'd1;
    end
  endtask

  task automatic check_regs();
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    chk("commit_store", 32'(commit_store), 32'(e_cs));
    chk("has_misbranch", 32'(has_misbranch), 32'(m_mis));
    if (e_cv) begin
      chk("commit_rd", 32'(commit_rd), 32'(e_rd));
      chk("commit_data", commit_data, e_data);
      chk("commit_robnum", 32'(commit_robnum), 32'(e_robnum));
    end
    if (e_cs) chk("commit_store_robnum", 32'(commit_store_robnum), 32'(e_csrob));
    if (m_mis) chk("target_pc", target_pc, e_target);
  endtask

  // One cycle: inputs already set at the falling edge.
  task automatic tick();
    #1;
    if (!rst) check_comb();
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_idle();
    rst = 1'b0; rdy = 1'b1; issue_rob = 1'b0; alu_valid = 1'b0; slb_valid = 1'b0;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1'b1; tick(); set_idle();
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] d, input logic [31:0] p,
                          input logic hj);
    set_idle(); issue_rob = 1'b1; inst_type = t; dest = d; pc = p; has_jump = hj; tick();
  endtask

  task automatic do_alu(input logic [3:0] tag, input logic [31:0] res, input logic j,
                        input logic [31:0] tgt);
    set_idle(); alu_valid = 1'b1; alu_robnum = tag; alu_result = res;
    alu_jump = j; alu_target = tgt; tick();
  endtask

  task automatic do_idle();
    set_idle(); tick();
  endtask

  initial begin
    int          cand[$];
    int          k;
    logic [3:0]  atag;
    rst = 1'b1; rdy = 1'b1; issue_rob = 1'b0; inst_type = '0; dest = '0; has_jump = 1'b0;
    pc = '0; rs1_rob_num = '0; rs2_rob_num = '0; alu_valid = 1'b0; alu_robnum = '0;
    alu_result = '0; alu_jump = 1'b0; alu_target = '0; slb_valid = 1'b0; slb_robnum = '0;
    slb_result = '0;
    q.delete(); m_tail = '0; m_mis = 1'b0;
    @(negedge clk);
    tick();
    set_idle();
    #1;
    chk("rst_avail", 32'(rob_avail), 32'd1);
    chk("rst_avail_num", 32'(rob_avail_num), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_misbranch", 32'(has_misbranch), 32'd0);
    chk("rst_target_pc", target_pc, 32'd0);

    // 14 back-to-back allocations, distinct tags, then the buffer reports full.
    for (int i = 0; i < 14; i++) begin
      set_idle(); issue_rob = 1'b1; inst_type = Other_Type; dest = 5'(i); pc = 32'(i * 4);
      #1;
      chk("alloc_num", 32'(rob_avail_num), 32'((i + 1) % 16));
      chk("alloc_avail", 32'(rob_avail), 32'd1);
      tick();
    end
    set_idle(); issue_rob = 1'b1;
    #1 chk("full_avail_issuing", 32'(rob_avail), 32'd0);
    issue_rob = 1'b0;
    #1 chk("full_avail_idle", 32'(rob_avail), 32'd1);
    chk("full_avail_num", 32'(rob_avail_num), 32'd14);
    tick();

    // Simple register commit.
    do_reset();
    do_issue(Other_Type, 5'd5, 32'h40, 1'b0);
    do_alu(4'd0, 32'h1234, 1'b0, 32'h0);
    do_idle();
    chk("lit_cv", 32'(commit_valid), 32'd1);
    chk("lit_rd", 32'(commit_rd), 32'd5);
    chk("lit_data", commit_data, 32'h1234);
    chk("lit_robnum", 32'(commit_robnum), 32'd0);

    // Same-cycle forwarding from the ALU bus.
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(Other_Type, 5'(i + 1), 32'(i * 4), 1'b0);
    set_idle(); alu_valid = 1'b1; alu_robnum = 4'd3; alu_result = 32'hAA;
    rs1_rob_num = 4'd3; rs2_rob_num = 4'd2;
    #1;
    chk("fwd_rs1_ready", 32'(rob_rs1_ready), 32'd1);
    chk("fwd_rs1_data", rob_rs1_data, 32'hAA);
    chk("fwd_rs2_ready", 32'(rob_rs2_ready), 32'd0);
    tick();

    // Mispredicted branch: one-cycle redirect, flush-cycle traffic is ignored.
    do_reset();
    do_issue(Branch_Type, 5'd0, 32'h100, 1'b0);
    do_alu(4'd0, 32'h0, 1'b1, 32'h200);
    do_idle();
    chk("mis_flag", 32'(has_misbranch), 32'd1);
    chk("mis_target", target_pc, 32'h200);
    set_idle(); issue_rob = 1'b1; inst_type = Other_Type;
    alu_valid = 1'b1; alu_robnum = 4'd0; alu_result = 32'hDEAD;
    slb_valid = 1'b1; slb_robnum = 4'd1; slb_result = 32'hBEEF;
    tick();
    chk("mis_pulse_end", 32'(has_misbranch), 32'd0);
    set_idle();
    #1 chk("mis_empty_tail", 32'(rob_avail_num), 32'd0);
    tick();
    chk("mis_no_commit", 32'(commit_valid), 32'd0);

    // Correctly predicted taken branch retires silently.
    do_reset();
    do_issue(Branch_Type, 5'd0, 32'h300, 1'b1);
    do_alu(4'd0, 32'h0, 1'b1, 32'h400);
    do_idle();
    chk("okbr_mis", 32'(has_misbranch), 32'd0);
    chk("okbr_cv", 32'(commit_valid), 32'd0);
    do_issue(Other_Type, 5'd9, 32'h304, 1'b0);
    do_alu(4'd1, 32'h99, 1'b0, 32'h0);
    do_idle();
    chk("okbr_next_cv", 32'(commit_valid), 32'd1);
    chk("okbr_next_robnum", 32'(commit_robnum), 32'd1);

    // Store then Other; SLB and ALU complete on the same cycle.
    do_reset();
    do_issue(Store_Type, 5'd0, 32'h500, 1'b0);
    do_issue(Other_Type, 5'd7, 32'h504, 1'b0);
    set_idle(); slb_valid = 1'b1; slb_robnum = 4'd0; slb_result = 32'h0;
    alu_valid = 1'b1; alu_robnum = 4'd1; alu_result = 32'h77; tick();
    do_idle();
    chk("st_commit_store", 32'(commit_store), 32'd1);
    chk("st_tag", 32'(commit_store_robnum), 32'd0);
    chk("st_no_cv", 32'(commit_valid), 32'd0);
    do_idle();
    chk("st_next_cv", 32'(commit_valid), 32'd1);
    chk("st_next_data", commit_data, 32'h77);

    // Tag wrap 15 -> 0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_issue(Other_Type, 5'((i % 31) + 1), 32'(i * 4), 1'b0);
      do_alu(4'(i % 16), 32'(i), 1'b0, 32'h0);
      do_idle();
      chk("wrap_robnum", 32'(commit_robnum), 32'(i % 16));
      chk("wrap_data", commit_data, 32'(i));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rdy = ($urandom_range(7) != 0);
      if (q.size() <= 13 && $urandom_range(1) == 1) begin
        issue_rob = 1'b1;
        inst_type = 2'($urandom_range(3));
        dest      = 5'($urandom);
        pc        = $urandom & 32'hFFFF_FFFC;
        has_jump  = 1'($urandom);
      end
      cand.delete();
      for (int i = 0; i < q.size(); i++)
        if (!q[i].done && q[i].typ != Store_Type) cand.push_back(i);
      atag = 4'hF;
      if (cand.size() > 0 && $urandom_range(3) != 0) begin
        k = cand[$urandom_range(cand.size() - 1)];
        alu_valid  = 1'b1;
        alu_robnum = q[k].tag;
        atag       = q[k].tag;
        alu_result = $urandom;
        alu_target = $urandom & 32'hFFFF_FFFC;
        alu_jump   = ($urandom_range(3) == 0) ? !q[k].pred : q[k].pred;
      end else if (m_mis && $urandom_range(1) == 1) begin
        alu_valid  = 1'b1;
        alu_robnum = 4'($urandom);
        alu_result = $urandom;
      end
      cand.delete();
      for (int i = 0; i < q.size(); i++)
        if (!q[i].done && (q[i].typ == Store_Type || q[i].typ == Other_Type) &&
            !(alu_valid && q[i].tag == atag))
          cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(2) != 0) begin
        k = cand[$urandom_range(cand.size() - 1)];
        slb_valid  = 1'b1;
        slb_robnum = q[k].tag;
        slb_result = $urandom;
      end
      if (q.size() > 0) begin
        rs1_rob_num = q[$urandom_range(q.size() - 1)].tag;
        rs2_rob_num = q[$urandom_range(q.size() - 1)].tag;
      end else begin
        rs1_rob_num = 4'($urandom);
        rs2_rob_num = 4'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
